// File: rtl/axis_insert_header_arbiter_pkg.sv
// Shared definitions for the header-insert arbiter: FSM encoding and the
// rotating-priority pick used by the round-robin picker.
package axis_insert_header_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  localparam int MAX_SRC = 16;

  // First set request bit searching upward from ptr+1, wrapping at n.
  // Walks the offsets from far to near so the nearest hit is the one kept.
  function automatic logic [3:0] rr_pick(input int n, input logic [3:0] ptr,
                                         input logic [MAX_SRC-1:0] req);
    logic [3:0] pick;
    logic [4:0] sum;
    pick = '0;
    for (int k = MAX_SRC; k >= 1; k--) begin
      sum = 5'(ptr) + 5'(k);
      if (sum >= 5'(n)) sum = sum - 5'(n);
      if (k <= n && req[sum[3:0]]) pick = sum[3:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_insert_header_arbiter_rr_arbiter.sv
// Round-robin picker: combinational pick from the request vector, priority
// pointer advanced to the finished grant on the update strobe.
module rr_arbiter
  import axis_insert_header_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_WD  = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               upd,
  input  logic [SRC_WD-1:0]  upd_idx,
  output logic [SRC_WD-1:0]  pick
);

  logic [SRC_WD-1:0] ptr;

  // Pointer starts at the top index so source 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= SRC_WD'(NUM_SRC - 1);
    else if (upd) ptr <= upd_idx;
  end

  assign pick = SRC_WD'(rr_pick(NUM_SRC, 4'(ptr), MAX_SRC'(req)));

endmodule

// File: rtl/axis_insert_header_arbiter.sv
// Shares one header inserter among NUM_SRC requesters. One source is granted
// per packet: its header is routed first, then its payload until last.
module axis_insert_header_arbiter
  import axis_insert_header_arbiter_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
  output logic [NUM_SRC-1:0]                s_ready_insert,
  input  logic [NUM_SRC-1:0]                s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
  input  logic [NUM_SRC-1:0]                s_last_in,
  output logic [NUM_SRC-1:0]                s_ready_in,
  output logic                              m_valid_insert,
  output logic [DATA_WD-1:0]                m_data_insert,
  output logic [DATA_BYTE_WD-1:0]           m_keep_insert,
  input  logic                              m_ready_insert,
  output logic                              m_valid_in,
  output logic [DATA_WD-1:0]                m_data_in,
  output logic [DATA_BYTE_WD-1:0]           m_keep_in,
  output logic                              m_last_in,
  input  logic                              m_ready_in,
  output logic [SRC_WD-1:0]                 grant_id,
  output logic                              busy
);

  logic [1:0]              state;
  logic [SRC_WD-1:0]       gnt;
  logic [SRC_WD-1:0]       pick;
  logic                    in_hdr, in_pay;
  logic                    hdr_fire, last_fire;
  logic [NUM_SRC-1:0]      gnt_oh;
  logic                    sel_vi, sel_vin, sel_lin;
  logic [DATA_WD-1:0]      sel_di, sel_din;
  logic [DATA_BYTE_WD-1:0] sel_ki, sel_kin;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_WD(SRC_WD)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (s_valid_insert),
    .upd     (last_fire),
    .upd_idx (gnt),
    .pick    (pick)
  );

  // Packet FSM: arbitrate in IDLE, hold the grant through header and payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|s_valid_insert) begin
          gnt   <= pick;
          state <= ST_HDR;
        end
        ST_HDR:     if (hdr_fire)  state <= ST_PAYLOAD;
        ST_PAYLOAD: if (last_fire) state <= ST_IDLE;
        default:                   state <= ST_IDLE;
      endcase
    end
  end

  // Select the granted source's channels; data/keep follow the grant always.
  always_comb begin
    gnt_oh  = '0;
    sel_vi  = 1'b0;
    sel_vin = 1'b0;
    sel_lin = 1'b0;
    sel_di  = '0;
    sel_ki  = '0;
    sel_din = '0;
    sel_kin = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt == SRC_WD'(i)) begin
        gnt_oh[i] = 1'b1;
        sel_vi    = s_valid_insert[i];
        sel_vin   = s_valid_in[i];
        sel_lin   = s_last_in[i];
        sel_di    = s_data_insert[i*DATA_WD +: DATA_WD];
        sel_ki    = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_din   = s_data_in[i*DATA_WD +: DATA_WD];
        sel_kin   = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
      end
    end
  end

  assign in_hdr = (state == ST_HDR);
  assign in_pay = (state == ST_PAYLOAD);

  assign m_valid_insert = in_hdr & sel_vi;
  assign m_data_insert  = sel_di;
  assign m_keep_insert  = sel_ki;
  assign s_ready_insert = (in_hdr && m_ready_insert) ? gnt_oh : '0;

  assign m_valid_in = in_pay & sel_vin;
  assign m_data_in  = sel_din;
  assign m_keep_in  = sel_kin;
  assign m_last_in  = sel_lin;
  assign s_ready_in = (in_pay && m_ready_in) ? gnt_oh : '0;

  assign hdr_fire  = m_valid_insert & m_ready_insert;
  assign last_fire = m_valid_in & m_ready_in & m_last_in;

  assign grant_id = gnt;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_axis_insert_header_arbiter.sv
// Randomized bench for the header-insert arbiter with a packet-level
// reference model (grant order, routing, readies) plus directed scenarios.
module tb_axis_insert_header_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int KW = 4;

  logic              clk = 0;
  logic              rst_n = 0;
  logic [NS-1:0]     s_valid_insert, s_ready_insert, s_valid_in, s_last_in, s_ready_in;
  logic [NS*DW-1:0]  s_data_insert, s_data_in;
  logic [NS*KW-1:0]  s_keep_insert, s_keep_in;
  logic              m_valid_insert, m_ready_insert, m_valid_in, m_last_in, m_ready_in;
  logic [DW-1:0]     m_data_insert, m_data_in;
  logic [KW-1:0]     m_keep_insert, m_keep_in;
  logic [1:0]        grant_id;
  logic              busy;

  axis_insert_header_arbiter #(.DATA_WD(DW), .NUM_SRC(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
    .s_keep_insert(s_keep_insert), .s_ready_insert(s_ready_insert),
    .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
    .s_last_in(s_last_in), .s_ready_in(s_ready_in),
    .m_valid_insert(m_valid_insert), .m_data_insert(m_data_insert),
    .m_keep_insert(m_keep_insert), .m_ready_insert(m_ready_insert),
    .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
    .m_last_in(m_last_in), .m_ready_in(m_ready_in),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source-side packet state
  bit         pend[NS], pay[NS], pv[NS];
  int         bidx[NS], blen[NS], pktn[NS], spawn_pct[NS];
  logic [31:0] hdr[NS];
  logic [3:0]  hkeep[NS], lkeep[NS];
  int         len_fix = 0, maxlen = 6;
  bit         gaps = 0, rdy_rand = 0;

  // Reference model: phase 0 idle, 1 header, 2 payload
  int mphase = 0, mgrant = 0, mptr = NS - 1;
  int ev_hdr = -1, ev_pay = -1;
  int cyc = 0;
  int grants[$];
  int done_cyc[$];

  function automatic int rr_ref(input int p, input logic [NS-1:0] r);
    for (int k = 1; k <= NS; k++)
      if (r[(p + k) % NS]) return (p + k) % NS;
    return -1;
  endfunction

  task automatic new_pkt(input int i);
    pend[i]  = 1;
    hdr[i]   = $urandom;
    hkeep[i] = 4'($urandom_range(15, 1));
    lkeep[i] = 4'($urandom_range(15, 1));
    blen[i]  = (len_fix > 0) ? len_fix : int'($urandom_range(maxlen, 1));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      s_valid_insert[i]         = pend[i];
      s_data_insert[i*DW +: DW] = hdr[i];
      s_keep_insert[i*KW +: KW] = hkeep[i];
      if (pay[i]) begin
        if (!pv[i]) pv[i] = gaps ? ($urandom_range(3) != 0) : 1'b1;
        s_valid_in[i]         = pv[i];
        s_data_in[i*DW +: DW] = {8'(i), 8'(pktn[i]), 16'(bidx[i])};
        s_last_in[i]          = (bidx[i] == blen[i] - 1);
        s_keep_in[i*KW +: KW] = s_last_in[i] ? lkeep[i] : 4'hF;
      end else begin
        // junk payload from a source without a grant: must never reach m_
        s_valid_in[i]         = 1'($urandom_range(1));
        s_data_in[i*DW +: DW] = $urandom;
        s_last_in[i]          = 1'($urandom_range(1));
        s_keep_in[i*KW +: KW] = 4'($urandom);
      end
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NS; i++) begin
      pend[i] = 0; pay[i] = 0; pv[i] = 0; bidx[i] = 0; blen[i] = 1;
      hdr[i] = 0; hkeep[i] = 0; lkeep[i] = 0;
    end
    ev_hdr = -1; ev_pay = -1;
    mphase = 0; mgrant = 0; mptr = NS - 1;
  endtask

  task automatic check_and_model();
    logic [NS-1:0] e_sri, e_srin;
    logic e_mvi, e_mvin;
    e_sri = '0; e_srin = '0; e_mvi = 0; e_mvin = 0;
    if (mphase == 1) begin e_mvi = s_valid_insert[mgrant]; e_sri[mgrant] = m_ready_insert; end
    if (mphase == 2) begin e_mvin = pv[mgrant] && pay[mgrant]; e_srin[mgrant] = m_ready_in; end
    chk("busy", busy, mphase != 0);
    chk("grant_id", grant_id, mgrant);
    chk("s_ready_insert", s_ready_insert, e_sri);
    chk("s_ready_in", s_ready_in, e_srin);
    chk("m_valid_insert", m_valid_insert, e_mvi);
    chk("m_valid_in", m_valid_in, e_mvin);
    if (e_mvi) begin
      chk("m_data_insert", m_data_insert, hdr[mgrant]);
      chk("m_keep_insert", m_keep_insert, hkeep[mgrant]);
    end
    if (e_mvin) begin
      chk("m_data_in", m_data_in, {8'(mgrant), 8'(pktn[mgrant]), 16'(bidx[mgrant])});
      chk("m_last_in", m_last_in, bidx[mgrant] == blen[mgrant] - 1);
      chk("m_keep_in", m_keep_in, (bidx[mgrant] == blen[mgrant] - 1) ? lkeep[mgrant] : 4'hF);
    end
    case (mphase)
      0: if (|s_valid_insert) begin
        mgrant = rr_ref(mptr, s_valid_insert);
        mphase = 1;
        grants.push_back(mgrant);
      end
      1: if (pend[mgrant] && m_ready_insert) begin
        mphase = 2;
        ev_hdr = mgrant;
      end
      2: if (pay[mgrant] && pv[mgrant] && m_ready_in) begin
        ev_pay = mgrant;
        if (bidx[mgrant] == blen[mgrant] - 1) begin
          mphase = 0;
          mptr = mgrant;
          done_cyc.push_back(cyc);
        end
      end
      default: ;
    endcase
  endtask

  task automatic update_sources();
    for (int i = 0; i < NS; i++) begin
      if (ev_hdr == i) begin pend[i] = 0; pay[i] = 1; bidx[i] = 0; pv[i] = 0; end
      if (ev_pay == i) begin
        bidx[i]++;
        pv[i] = 0;
        if (bidx[i] == blen[i]) begin pay[i] = 0; pktn[i]++; end
      end
      if (!pend[i] && !pay[i] && (int'($urandom_range(99)) < spawn_pct[i])) new_pkt(i);
    end
    ev_hdr = -1; ev_pay = -1;
    m_ready_insert = rdy_rand ? ($urandom_range(2) != 0) : 1'b1;
    m_ready_in     = rdy_rand ? ($urandom_range(2) != 0) : 1'b1;
    drive_inputs();
  endtask

  // One clock: check at the falling edge, then advance sources after the rise.
  task automatic step();
    @(negedge clk);
    cyc++;
    check_and_model();
    @(posedge clk);
    #1;
    update_sources();
  endtask

  task automatic set_spawn(input int a, input int b, input int c, input int d);
    spawn_pct[0] = a; spawn_pct[1] = b; spawn_pct[2] = c; spawn_pct[3] = d;
  endtask

  initial begin
    int c0, n;
    bit found;
    for (int i = 0; i < NS; i++) pktn[i] = 0;
    set_spawn(0, 0, 0, 0);
    clear_sources();
    m_ready_insert = 1; m_ready_in = 1;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_s_ready_insert", s_ready_insert, 0);
    chk("rst_s_ready_in", s_ready_in, 0);
    chk("rst_m_valid_insert", m_valid_insert, 0);
    chk("rst_m_valid_in", m_valid_in, 0);
    @(posedge clk); #1 rst_n = 1;

    // Single source 2, three beats
    len_fix = 3;
    new_pkt(2);
    hdr[2] = 32'hA5A5_0001; hkeep[2] = 4'b0111;
    drive_inputs();
    c0 = cyc + 1;
    repeat (8) step();
    chk("single_grant", (grants.size() > 0) ? grants[0] : -1, 2);
    chk("single_pkts", pktn[2], 1);
    chk("single_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1, 4);

    // Random traffic with gaps, backpressure and junk payload valids
    len_fix = 0; maxlen = 6; gaps = 1; rdy_rand = 1;
    set_spawn(30, 30, 30, 30);
    repeat (3000) step();

    // Drain, then back-to-back single-beat packets from source 3
    set_spawn(0, 0, 0, 0);
    n = 0;
    while (n < 500 && !(mphase == 0 && !pend[0] && !pay[0] && !pend[1] && !pay[1]
                        && !pend[2] && !pay[2] && !pend[3] && !pay[3])) begin
      step(); n++;
    end
    chk("drain_timeout", n < 500, 1);
    gaps = 0; rdy_rand = 0; len_fix = 1;
    set_spawn(0, 0, 0, 100);
    done_cyc.delete();
    repeat (20) step();
    chk("b2b_count", done_cyc.size() >= 5, 1);
    for (int k = 0; k + 1 < done_cyc.size() && k < 4; k++)
      chk("b2b_period", done_cyc[k+1] - done_cyc[k], 3);

    // Reset during payload beat 2 of 4
    len_fix = 4; rdy_rand = 1;
    set_spawn(100, 100, 100, 100);
    found = 0; n = 0;
    while (!found && n < 2000) begin
      step(); n++;
      if (mphase == 2 && pay[mgrant] && bidx[mgrant] == 1) found = 1;
    end
    chk("midrst_found", found, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_s_ready_in", s_ready_in, 0);
    chk("midrst_s_ready_insert", s_ready_insert, 0);
    chk("midrst_m_valid_in", m_valid_in, 0);
    chk("midrst_m_valid_insert", m_valid_insert, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant", grant_id, 0);
    clear_sources();
    drive_inputs();
    grants.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1;

    // All four requesting continuously after reset: 0,1,2,3,0
    len_fix = 0; maxlen = 3; rdy_rand = 0;
    repeat (60) step();
    chk("rr_grant_count", grants.size() >= 5, 1);
    if (grants.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_order", grants[k], k % NS);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/axis_insert_header_arbiter.md
Name: axis_insert_header_arbiter

Overview:
- Round-robin scheduler that shares one axi_stream_insert_header instance among NUM_SRC requesters.
- Each requester owns a header channel (insert) and a payload channel (in).
- The arbiter grants one requester per packet and routes its header, then its payload, to the shared inserter.
- It holds the grant until the payload beat with last is accepted, so packets are never interleaved.

Parameters:
- DATA_WD, 32, data bus width in bits.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- NUM_SRC, 4, number of requesters (2..16).
- SRC_WD, $clog2(NUM_SRC), width of grant index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid_insert  in  NUM_SRC  per-source header valid; also the arbitration request.
- s_data_insert  in  NUM_SRC*DATA_WD  per-source header data, source i at [i*DATA_WD +: DATA_WD].
- s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep.
- s_ready_insert  out  NUM_SRC  per-source header ready.
- s_valid_in  in  NUM_SRC  per-source payload valid.
- s_data_in  in  NUM_SRC*DATA_WD  per-source payload data.
- s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source payload keep.
- s_last_in  in  NUM_SRC  per-source payload last.
- s_ready_in  out  NUM_SRC  per-source payload ready.
- m_valid_insert  out  1  header valid to inserter.
- m_data_insert  out  DATA_WD  header data to inserter.
- m_keep_insert  out  DATA_BYTE_WD  header keep to inserter.
- m_ready_insert  in  1  header ready from inserter.
- m_valid_in  out  1  payload valid to inserter.
- m_data_in  out  DATA_WD  payload data to inserter.
- m_keep_in  out  DATA_BYTE_WD  payload keep to inserter.
- m_last_in  out  1  payload last to inserter.
- m_ready_in  in  1  payload ready from inserter.
- grant_id  out  SRC_WD  registered index of the current or last granted source.
- busy  out  1  high while in HDR or PAYLOAD.

Behaviour:
- Reset is asynchronous. State goes to IDLE, grant_id to 0, priority pointer to NUM_SRC-1 (source 0 wins first). All m_* valids and all s_ready_* are 0; busy is 0.
- IDLE:
  - Request vector is s_valid_insert.
  - If any bit is set, pick the first set bit searching from pointer+1 with wrap-around (pointer NUM_SRC-1 wraps to 0).
  - Register it into grant_id and go to HDR on the next edge. Arbitration latency is 1 cycle.
  - No ready is asserted in IDLE.
- HDR:
  - m_*_insert = granted source's header fields.
  - s_ready_insert[grant_id] = m_ready_insert; all other s_ready_insert are 0.
  - The payload path is blocked: m_valid_in = 0 and all s_ready_in = 0.
  - On m_valid_insert && m_ready_insert, go to PAYLOAD.
- PAYLOAD:
  - m_*_in = granted source's payload fields.
  - s_ready_in[grant_id] = m_ready_in; all others are 0.
  - The header path is blocked.
  - On m_valid_in && m_ready_in && m_last_in: go to IDLE and set pointer = grant_id.
- Routing is combinational from the state and grant_id registers; the arbiter adds no data latency.
- Non-granted m_data/m_keep are don't-care while m_valid is 0; drive them from the granted source to avoid extra muxing.
- Simultaneous requests: the strict rotating order guarantees no source waits more than NUM_SRC-1 packets.
- Request dropped before the header handshake (protocol violation by the source): the grant is held and the arbiter waits in HDR. No re-arbitration.
- Back-to-back packets: the cycle after the last beat is IDLE, so there is a minimum 1 idle cycle between packets on the m_ side.
- Single-beat payload (last on the first beat) is legal. Zero-beat payload is not supported.
- Reset mid-packet: immediate return to IDLE and readies drop to 0. Partial packets are not flushed; the sources must also be reset.
- Payload valid from a non-granted source is ignored and is not a request.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, HDR=2'd1, PAYLOAD=2'd2) and a helper function for rotating priority select (pointer, request) -> index.
- One natural sub-module: rr_arbiter, a parameterised NUM_SRC round-robin picker with a registered pointer and an update strobe.
- The top module contains the FSM and the muxes.

Test Plan:
- Single source: only source 2 requests with header 0xA5A5_0001, keep 4'b0111, then 3 payload beats with last on beat 3 → grant_id=2 one cycle after request; m_ header matches; 3 payload beats forwarded in order; busy drops after the beat-3 handshake.
- All four sources request continuously after reset → grant order 0,1,2,3,0; no payload beat from a non-granted source appears on m_.
- Downstream backpressure: m_ready_insert=0 for 5 cycles in HDR, then m_ready_in toggling 1,0,1 in PAYLOAD → state holds, s_ready mirrors m_ready for the granted source only, data stable while stalled.
- Source 1 is mid-payload when source 0 raises its request → source 0 is not granted until source 1's last beat is accepted plus 1 IDLE cycle; next grant_id=2 if source 2 was also requesting, else 0.
- Assert rst_n low during PAYLOAD beat 2 of 4 → all s_ready and m_valid go to 0 immediately; after release, the first grant goes to the lowest requesting index starting from 0.
- Single-beat packets back-to-back from source 3 alone → each packet takes 3 cycles (arbitrate, header, beat); m_last_in is asserted on the only payload beat.
